// File: rtl/axis_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream frame sink.
package axis_sink_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    HOLD    = 2'b10
  } state_t;

  // Buffer address width; a depth of 1 still needs one address bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Frame length must be able to represent the full depth.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One byte lane: all ones when the strobe is set, zero otherwise.
  function automatic logic [7:0] lane_mask(input logic en);
    return {8{en}};
  endfunction

endpackage

// File: rtl/axis_sink_buf.sv
// Frame buffer: byte-masked synchronous write, registered read.
// Lanes with a cleared strobe are stored as zero, not left unchanged.
module axis_sink_buf
  import axis_sink_pkg::*;
#(
  parameter int DW    = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_width(DEF_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata_m;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign wdata_m[b*8 +: 8] = wdata[b*8 +: 8] & lane_mask(wstrb[b]);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata_m;
  end

  // Read port runs every cycle; output register is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_stream_sink.sv
// AXI4-Stream slave that captures one frame, holds it for random-access
// reads, and releases it on frame_ack.
// Optional: define AXIS_SINK_SEQ_CHECK_EN to flag words that break the
// 1,2,3,... counting sequence (seq_err, sticky until the next IDLE).
module axis_stream_sink
  import axis_sink_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH  = DEF_DATA_W,
  parameter int NUMBER_OF_INPUT_WORDS = DEF_DEPTH,
  localparam int PTR_W = ptr_width(NUMBER_OF_INPUT_WORDS),
  localparam int LEN_W = len_width(NUMBER_OF_INPUT_WORDS)
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              frame_valid,
  output logic [LEN_W-1:0]                  frame_len,
  output logic                              frame_trunc,
  input  logic                              frame_ack,
  input  logic [PTR_W-1:0]                  rd_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic                              seq_err
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr;
  logic             tready_q;
  logic             accept, last_slot, frame_end;

  assign accept    = S_AXIS_TVALID & tready_q;
  assign last_slot = (wr_ptr == PTR_W'(NUMBER_OF_INPUT_WORDS - 1));
  assign frame_end = accept & (S_AXIS_TLAST | last_slot);

  assign S_AXIS_TREADY = tready_q;
  assign frame_valid   = (state_q == HOLD);

  // Next-state: one IDLE cycle, receive until TLAST or full, hold until ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RECEIVE;
      RECEIVE: if (frame_end) state_d = HOLD;
      HOLD:    if (frame_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Ready is registered from the next state so it drops on the edge that
  // closes the frame and never depends on TVALID.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) tready_q <= 1'b0;
    else                 tready_q <= (state_d == RECEIVE);
  end

  // Write pointer and frame descriptor; length is captured on the closing word.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr      <= '0;
      frame_len   <= '0;
      frame_trunc <= 1'b0;
    end else if (state_q == IDLE) begin
      wr_ptr      <= '0;
      frame_trunc <= 1'b0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (frame_end) begin
        frame_len   <= LEN_W'(wr_ptr) + LEN_W'(1);
        frame_trunc <= ~S_AXIS_TLAST;
      end
    end
  end

`ifdef AXIS_SINK_SEQ_CHECK_EN
  logic [DW-1:0] exp_q;
  logic          seq_err_q;

  // Expected-value counter; any mismatch latches seq_err until IDLE.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      exp_q     <= DW'(1);
      seq_err_q <= 1'b0;
    end else if (accept) begin
      exp_q <= exp_q + DW'(1);
      if (S_AXIS_TDATA != exp_q) seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  axis_sink_buf #(
    .DW    (DW),
    .DEPTH (NUMBER_OF_INPUT_WORDS),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (S_AXIS_TDATA),
    .wstrb (S_AXIS_TSTRB),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_axis_stream_sink.sv
// Bench for axis_stream_sink: frame-level reference model plus directed
// frames with hand-computed expectations. Honors AXIS_SINK_SEQ_CHECK_EN.
module tb_axis_stream_sink;

  localparam int DW = 32, DEPTH = 8, LW = 4, AW = 3;
`ifdef AXIS_SINK_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic          clk = 1'b0, rstn = 1'b1;
  logic          tready, fv, ftrunc, serr;
  logic          tvalid = 1'b0, tlast = 1'b0, ack = 1'b0;
  logic [DW-1:0] tdata = '0, rdd;
  logic [3:0]    tstrb = 4'hF;
  logic [LW-1:0] flen;
  logic [AW-1:0] raddr = '0;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  axis_stream_sink #(.C_S_AXIS_TDATA_WIDTH(DW), .NUMBER_OF_INPUT_WORDS(DEPTH)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn), .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .frame_valid(fv), .frame_len(flen),
    .frame_trunc(ftrunc), .frame_ack(ack), .rd_addr(raddr),
    .rd_data(rdd), .seq_err(serr)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Phase 0: gap cycle, 1: collecting words, 2: frame held for the reader.
  int          m_ph = 0, m_len = 0, m_n = 0;
  bit          m_ready = 0, m_fv = 0, m_trunc = 0, m_seq = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = 0; m_ready = 0; m_fv = 0; m_len = 0; m_trunc = 0; m_seq = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd_known = m_known[raddr];
      m_rd       = m_mem[raddr];
      case (m_ph)
        0: begin m_ph = 1; m_ready = 1; m_trunc = 0; m_seq = 0; m_n = 0; end
        1: if (tvalid) begin
          m_mem[m_n] = masked(tdata, tstrb);
          m_known[m_n] = 1;
          if (SEQ && tdata != 32'(m_n + 1)) m_seq = 1;
          m_n++;
          if (tlast || m_n == DEPTH) begin
            m_ph = 2; m_ready = 0; m_fv = 1; m_len = m_n; m_trunc = !tlast;
          end
        end
        default: if (ack) begin m_ph = 0; m_fv = 0; end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("tready", tready, m_ready);
    chk("frame_valid", fv, m_fv);
    chk("frame_len", flen, m_len);
    chk("frame_trunc", ftrunc, m_trunc);
    chk("seq_err", serr, m_seq);
    if (m_rd_known) chk("rd_data", rdd, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end at posedge+1.
  task automatic send(input logic [31:0] d, input logic [3:0] s, input bit l);
    int n = 0;
    bit done = 0;
    tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk); n++;
      if (tready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_fv();
    int n = 0;
    while (!fv && n < 100) begin @(negedge clk); n++; end
    if (!fv) chk("frame_valid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_ack();
    ack = 1'b1; @(posedge clk); #1; ack = 1'b0;
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
    raddr = a; @(posedge clk); #1;
    chk(nm, rdd, exp);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_tready", tready, 0);
    chk("rst_fv", fv, 0);
    chk("rst_len", flen, 0);
    chk("rst_rd", rdd, 0);
    @(negedge clk); rstn = 1'b1;
    #1 chk("tready_at_release", tready, 0);
    @(posedge clk); #1 chk("tready_1cyc_after_release", tready, 1);

    // 1: full 8-word frame, then read it back
    for (int i = 1; i <= 8; i++) send(32'(i), 4'hF, i == 8);
    idle(); wait_fv();
    chk("t1_len", flen, 8);
    chk("t1_trunc", ftrunc, 0);
    chk("t1_seq", serr, 0);
    for (int a = 0; a < 8; a++) rd_chk(AW'(a), 32'(a + 1), "t1_read");
    do_ack();

    // 2: short frame, ack turnaround
    send(32'hA, 4'hF, 0); send(32'hB, 4'hF, 0); send(32'hC, 4'hF, 1);
    chk("t2_tready_drop", tready, 0);
    idle();
    chk("t2_len", flen, 3);
    chk("t2_trunc", ftrunc, 0);
    rd_chk(3'd2, 32'hC, "t2_read2");
    do_ack();
    chk("t2_tready_ack_edge", tready, 0);
    @(posedge clk); #1 chk("t2_tready_back", tready, 1);

    // 3: overlength frame truncates; overflow words start the next frame
    fork
      begin
        for (int i = 1; i <= 10; i++) send(32'h100 + 32'(i), 4'hF, 0);
        send(32'h1FF, 4'hF, 1);
        idle();
      end
      begin
        wait_fv();
        chk("t3_len", flen, 8);
        chk("t3_trunc", ftrunc, 1);
        repeat (3) @(posedge clk); #1;
        chk("t3_stall", tready, 0);
        rd_chk(3'd7, 32'h108, "t3_read7");
        do_ack();
      end
    join
    wait_fv();
    chk("t3b_len", flen, 3);
    chk("t3b_trunc", ftrunc, 0);
    rd_chk(3'd0, 32'h109, "t3b_read0");
    do_ack();

    // 4: TVALID every other cycle with partial strobes
    for (int k = 0; k < 4; k++) begin
      send(32'hDEADBEEF, 4'b0101, k == 3);
      idle(); @(posedge clk); #1;
    end
    wait_fv();
    chk("t4_len", flen, 4);
    rd_chk(3'd0, 32'h00AD00EF, "t4_read0");
    rd_chk(3'd3, 32'h00AD00EF, "t4_read3");
    do_ack();

    // 5: asynchronous reset mid-frame
    for (int i = 1; i <= 4; i++) send(32'(i), 4'hF, 0);
    idle();
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_tready", tready, 0);
    chk("t5_async_len", flen, 0);
    chk("t5_async_rd", rdd, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1 chk("t5_tready_after", tready, 1);
    for (int i = 1; i <= 8; i++) send(32'(i), 4'hF, i == 8);
    idle(); wait_fv();
    chk("t5_len", flen, 8);
    rd_chk(3'd4, 32'd5, "t5_read4");
    do_ack();

    // 6: broken counting sequence
    begin
      logic [31:0] sq [8] = '{32'd1, 32'd2, 32'd4, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      for (int i = 0; i < 8; i++) send(sq[i], 4'hF, i == 7);
    end
    idle(); wait_fv();
    chk("t6_seq_hold", serr, SEQ ? 32'd1 : 32'd0);
    do_ack();
    @(posedge clk); #1;
    chk("t6_seq_cleared", serr, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/axis_stream_sink.md
Name: axis_stream_sink

Overview:
AXI4-Stream slave (receiver) that accepts one frame of up to NUMBER_OF_INPUT_WORDS words into an internal buffer. It then holds the frame for local logic to read through a random-access port, and releases the buffer on acknowledge. It pairs with the team's fixed-length AXI-Stream master test source as the far end of the same link.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, data width in bits; multiple of 8.
NUMBER_OF_INPUT_WORDS, 8, buffer depth in words; maximum frame length; >= 2.

Ports:
S_AXIS_ACLK  in  1  clock; all logic on rising edge.
S_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low.
S_AXIS_TREADY  out  1  slave ready.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data.
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers.
S_AXIS_TLAST  in  1  end of frame.
S_AXIS_TVALID  in  1  master valid.
frame_valid  out  1  buffer holds a complete frame.
frame_len  out  clog2(NUMBER_OF_INPUT_WORDS+1)  words stored, 1..NUMBER_OF_INPUT_WORDS.
frame_trunc  out  1  frame filled the buffer without TLAST.
frame_ack  in  1  release buffer; meaningful only while frame_valid=1.
rd_addr  in  clog2(NUMBER_OF_INPUT_WORDS)  buffer read address.
rd_data  out  C_S_AXIS_TDATA_WIDTH  buffer word; registered.
seq_err  out  1  sequence-check error, sticky per frame.

Behaviour:
- Reset: one clock, S_AXIS_ACLK; asynchronous active-low reset, S_AXIS_ARESETN. While reset is asserted: state=IDLE, write_pointer=0, S_AXIS_TREADY=0, frame_valid=0, frame_len=0, frame_trunc=0, seq_err=0, rd_data=0. Buffer contents are not reset.
- Handshake: a word is accepted on a rising edge where TVALID=1 and TREADY=1. TREADY is a registered output and equals 1 only in state RECEIVE. TREADY does not depend combinationally on TVALID.
- State IDLE: lasts one cycle, then moves to RECEIVE. write_pointer is cleared, and frame_trunc and seq_err are cleared here.
- State RECEIVE: on each accepted word, write the word to buf[write_pointer] and increment write_pointer.
  - Exit to HOLD on an accepted word with TLAST=1. frame_len = write_pointer+1.
  - Exit to HOLD on an accepted word at write_pointer=NUMBER_OF_INPUT_WORDS-1 with TLAST=0. frame_len = NUMBER_OF_INPUT_WORDS and frame_trunc=1.
  - TREADY drops in the same edge that enters HOLD, so no word is accepted in the cycle after the last one.
  - Any words the master sends beyond the truncation point are not accepted; they stall until the next frame.
- State HOLD: TREADY=0 and frame_valid=1. frame_len and frame_trunc are stable. On frame_ack=1, move to IDLE and deassert frame_valid on that edge. frame_ack in any other state is ignored.
- Byte strobes: a byte lane with TSTRB=0 is written as 8'h00; the other lanes are written with TDATA.
- Read port: rd_data <= buf[rd_addr] every cycle in all states. Latency is 1 cycle. Addresses >= frame_len return stale contents and no error is raised.
- Reset mid-frame: the partial frame is discarded. After release, the block starts in IDLE, so the minimum gap before TREADY is 1 cycle.
- Minimum frame turnaround: frame_ack edge -> 1 IDLE cycle -> TREADY=1.

Optional Feature:
Macro AXIS_SINK_SEQ_CHECK_EN.
- Defined: an expected counter is set to 1 in IDLE and incremented on every accepted word. If an accepted TDATA differs from the counter, seq_err is set. seq_err is sticky until the next IDLE.
- Not defined: seq_err is tied 0 and no counter logic is present.

Decomposition:
- Package axis_sink_pkg: state encoding (IDLE=2'b00, RECEIVE=2'b01, HOLD=2'b10), pointer and length width constants, and a byte-mask expansion function.
- Sub-module axis_sink_buf: NUMBER_OF_INPUT_WORDS x C_S_AXIS_TDATA_WIDTH buffer with a byte-masked synchronous write and a registered read.
- The top level contains the FSM, pointers, flags and the sequence checker.

Test Plan:
1. Reset, then TVALID held high with data 1..8 and TLAST on word 8.
   -> TREADY first goes high 1 cycle after reset release.
   -> 8 consecutive accepts, then frame_valid=1, frame_len=8, frame_trunc=0, seq_err=0.
   -> Reading addresses 0..7 returns 1..8, each 1 cycle after the address is applied.
2. 3-word frame 0xA,0xB,0xC with TLAST on the third word.
   -> frame_len=3, frame_trunc=0, TREADY=0 from the next cycle.
   -> frame_ack returns the block to IDLE, and TREADY=1 again 2 edges after the ack.
3. 10 words with no TLAST.
   -> Exactly 8 accepted, then frame_len=8 and frame_trunc=1.
   -> Words 9-10 stall with TREADY=0 and are accepted into the next frame after frame_ack.
4. TVALID toggling every other cycle with TSTRB=4'b0101 and data 0xDEADBEEF.
   -> Stored word reads 0x00AD00EF.
   -> Accept count matches the number of TVALID cycles, with no extra or lost words.
5. Reset asserted asynchronously after 4 words, then released.
   -> Outputs go to reset values immediately, without waiting for a clock edge.
   -> A new 8-word frame is received with frame_len=8.
6. With AXIS_SINK_SEQ_CHECK_EN defined, send data 1,2,4,4,5,6,7,8 with TLAST on word 8.
   -> seq_err=1 in HOLD; it is cleared after frame_ack and IDLE.
   -> Without the macro, the same stimulus leaves seq_err=0.
